// File: rtl/adc_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_conv_sequencer
//  Description : Conversion controller for the ADC digital back-ends (Flash,
//                SAR conventional, SAR monotonic). It generates the shared
//                sample strobe, times the sample and convert phases, waits
//                for the selected back-end's end-of-conversion, averages
//                2^avg_log2 conversions and publishes the averaged result
//                through a valid/ready handshake.
//
//  Ports:
//    wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//    start, continuous           conversion request / auto-restart enable
//    mode, avg_log2              back-end select / averaging depth (latched)
//    clear_flags                 clears the overrun and timeout sticky flags
//    eoc_*, b_*                  back-end end-of-conversion levels and results
//    samp, sel, busy             sample strobe, latched mode, activity flag
//    result, result_valid,
//    result_ready                averaged result handshake
//    overrun, timeout            sticky error flags
//
//  Revision    : 1.0  initial release
// ============================================================================
module adc_conv_sequencer #(
    parameter int NBITS          = 10,
    parameter int SAMP_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             continuous,
    input  logic [1:0]       mode,
    input  logic [1:0]       avg_log2,
    input  logic             clear_flags,
    input  logic             eoc_flash,
    input  logic             eoc_conv,
    input  logic             eoc_monot,
    input  logic [NBITS-1:0] b_flash,
    input  logic [NBITS-1:0] b_conv,
    input  logic [NBITS-1:0] b_monot,
    output logic             samp,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             timeout
);

    // Three extra bits hold the sum of up to eight full-scale conversions.
    localparam int c_acc_w = NBITS + 3;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_sample  = 2'd1;
    localparam logic [1:0] c_st_convert = 2'd2;
    localparam logic [1:0] c_st_publish = 2'd3;

    localparam logic [7:0] c_samp_last = 8'(SAMP_CYCLES - 1);
    localparam logic [7:0] c_timeout   = 8'(TIMEOUT_CYCLES);

    logic [1:0]         r_state;
    logic [7:0]         r_phase;     // sample-length counter in SAMPLE, timeout counter in CONVERT
    logic [3:0]         r_cnt;       // conversions accumulated so far
    logic [c_acc_w-1:0] r_acc;
    logic [1:0]         r_sel;
    logic [1:0]         r_avg;
    logic               r_samp;
    logic [NBITS-1:0]   r_result;
    logic               r_valid;
    logic               r_overrun;
    logic               r_timeout;

    logic               w_eoc_sel;
    logic [NBITS-1:0]   w_b_sel;
    logic [c_acc_w-1:0] w_acc_sum;
    logic [3:0]         w_cnt_next;
    logic [3:0]         w_cnt_target;
    logic [7:0]         w_phase_next;

    // Only the latched back-end is observed; the others are masked here.
    always_comb begin
        w_eoc_sel = 1'b0;
        w_b_sel   = '0;
        case (r_sel)
            2'b01: begin
                w_eoc_sel = eoc_flash;
                w_b_sel   = b_flash;
            end
            2'b10: begin
                w_eoc_sel = eoc_conv;
                w_b_sel   = b_conv;
            end
            2'b11: begin
                w_eoc_sel = eoc_monot;
                w_b_sel   = b_monot;
            end
            default: begin
                w_eoc_sel = 1'b0;
                w_b_sel   = '0;
            end
        endcase
    end

    assign w_acc_sum    = r_acc + {3'b000, w_b_sel};
    assign w_cnt_next   = r_cnt + 4'd1;
    assign w_cnt_target = 4'd1 << r_avg;
    assign w_phase_next = r_phase + 8'd1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_st_idle;
            r_phase   <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_sel     <= 2'b00;
            r_avg     <= 2'b00;
            r_samp    <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // Consumer accept; a publish later in this block overrides it.
            if (r_valid && result_ready) begin
                r_valid <= 1'b0;
            end
            // Flag clear comes first so a coincident set event wins.
            if (clear_flags) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (start && (mode != 2'b00)) begin
                        r_sel   <= mode;
                        r_avg   <= avg_log2;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_phase <= '0;
                        r_samp  <= 1'b1;
                        r_state <= c_st_sample;
                    end
                end

                c_st_sample: begin
                    if (r_phase == c_samp_last) begin
                        r_phase <= '0;
                        r_samp  <= 1'b0;
                        r_state <= c_st_convert;
                    end else begin
                        r_phase <= w_phase_next;
                    end
                end

                c_st_convert: begin
                    // eoc is ignored on the first CONVERT cycle so a level
                    // left over from the previous conversion is not counted.
                    if (w_eoc_sel && (r_phase != 8'd0)) begin
                        r_acc   <= w_acc_sum;
                        r_cnt   <= w_cnt_next;
                        r_phase <= '0;
                        if (w_cnt_next == w_cnt_target) begin
                            r_state <= c_st_publish;
                        end else begin
                            r_samp  <= 1'b1;
                            r_state <= c_st_sample;
                        end
                    end else if (w_phase_next == c_timeout) begin
                        r_timeout <= 1'b1;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_phase   <= '0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_phase <= w_phase_next;
                    end
                end

                c_st_publish: begin
                    r_result <= NBITS'(r_acc >> r_avg);
                    r_valid  <= 1'b1;
                    // An unread result is being replaced.
                    if (r_valid && !result_ready) begin
                        r_overrun <= 1'b1;
                    end
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_phase <= '0;
                    if (continuous) begin
                        r_sel <= mode;
                        r_avg <= avg_log2;
                        if (mode != 2'b00) begin
                            r_samp  <= 1'b1;
                            r_state <= c_st_sample;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_samp  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign samp         = r_samp;
    assign sel          = r_sel;
    assign busy         = (r_state != c_st_idle);
    assign result       = r_result;
    assign result_valid = r_valid;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_conv_sequencer
//  Description : Directed self-checking bench for adc_conv_sequencer with
//                hand-computed expected values (NBITS=10, SAMP_CYCLES=2,
//                TIMEOUT_CYCLES=64).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_conv_sequencer;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] avg_log2 = 2'b00;
    logic       clear_flags = 1'b0;
    logic       eoc_flash = 1'b0;
    logic       eoc_conv = 1'b0;
    logic       eoc_monot = 1'b0;
    logic [9:0] b_flash = '0;
    logic [9:0] b_conv = '0;
    logic [9:0] b_monot = '0;
    logic       samp;
    logic [1:0] sel;
    logic       busy;
    logic [9:0] result;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic       overrun;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    adc_conv_sequencer #(
        .NBITS          (10),
        .SAMP_CYCLES    (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .start        (start),
        .continuous   (continuous),
        .mode         (mode),
        .avg_log2     (avg_log2),
        .clear_flags  (clear_flags),
        .eoc_flash    (eoc_flash),
        .eoc_conv     (eoc_conv),
        .eoc_monot    (eoc_monot),
        .b_flash      (b_flash),
        .b_conv       (b_conv),
        .b_monot      (b_monot),
        .samp         (samp),
        .sel          (sel),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Wait out one SAMPLE phase (counting samp cycles), stay wait_cyc cycles
    // in CONVERT, then present one eoc pulse on the chosen back-end.
    task automatic run_one(input logic [1:0] which, input logic [9:0] val,
                           input int wait_cyc, output int ns);
        int g;
        ns = 0;
        g  = 0;
        while (!samp && g < 50) begin tick(); g++; end
        while (samp && ns < 50) begin ns++; tick(); end
        repeat (wait_cyc) tick();
        case (which)
            2'd1: begin eoc_flash = 1'b1; b_flash = val; end
            2'd2: begin eoc_conv  = 1'b1; b_conv  = val; end
            2'd3: begin eoc_monot = 1'b1; b_monot = val; end
            default: ;
        endcase
        tick();
        eoc_flash = 1'b0;
        eoc_conv  = 1'b0;
        eoc_monot = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
        n_cmp++; if ({samp, sel, busy, result, result_valid, overrun, timeout} !== 17'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", {samp, sel, busy, result, result_valid, overrun, timeout}); end
        tick();
        n_cmp++; if ({samp, busy} !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", {samp, busy}); end
    endtask

    task automatic test_single();
        int ns;
        mode = 2'b10; avg_log2 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (sel !== 2'b10) begin n_err++; $display("FAIL single_sel: got %b want 10", sel); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        run_one(2'd2, 10'h2A5, 5, ns);
        n_cmp++; if (ns !== 2) begin n_err++; $display("FAIL single_samp_len: got %0d want 2", ns); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", result_valid); end
        tick();
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", result_valid); end
        n_cmp++; if (result !== 10'h2A5) begin n_err++; $display("FAIL single_result: got %h want 2a5", result); end
        n_cmp++; if ({busy, samp} !== 2'b00) begin n_err++; $display("FAIL single_idle: got %b want 00", {busy, samp}); end
        accept();
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL single_accept: got %b want 0", result_valid); end
    endtask

    task automatic test_average4();
        int ns;
        int sum;
        int hi;
        logic [9:0] vals [4] = '{10'd100, 10'd101, 10'd102, 10'd104};
        mode = 2'b11; avg_log2 = 2'd2; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b01; avg_log2 = 2'd0;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            run_one(2'd3, vals[i], 2, ns);
            sum += ns;
        end
        n_cmp++; if (sum !== 8) begin n_err++; $display("FAIL avg4_samp_cycles: got %0d want 8", sum); end
        n_cmp++; if (sel !== 2'b11) begin n_err++; $display("FAIL avg4_sel: got %b want 11", sel); end
        tick();
        n_cmp++; if (result !== 10'd101) begin n_err++; $display("FAIL avg4_result: got %0d want 101", result); end
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL avg4_valid: got %b want 1", result_valid); end
        hi = 0;
        accept();
        repeat (3) begin if (samp) hi = 1; tick(); end
        n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL avg4_extra_samp: got %0d want 0", hi); end
    endtask

    task automatic test_average8_max();
        int ns;
        mode = 2'b10; avg_log2 = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) run_one(2'd2, 10'h3FF, 1, ns);
        tick();
        n_cmp++; if (result !== 10'h3FF) begin n_err++; $display("FAIL avg8_max_result: got %h want 3ff", result); end
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL avg8_max_valid: got %b want 1", result_valid); end
        accept();
    endtask

    task automatic test_overrun();
        int ns;
        continuous = 1'b1; mode = 2'b01; avg_log2 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_one(2'd1, 10'h111, 2, ns);
        tick();
        n_cmp++; if (result !== 10'h111) begin n_err++; $display("FAIL ovr_first_result: got %h want 111", result); end
        n_cmp++; if ({busy, overrun} !== 2'b10) begin n_err++; $display("FAIL ovr_first_state: got %b want 10", {busy, overrun}); end
        mode = 2'b00;
        run_one(2'd1, 10'h222, 2, ns);
        tick();
        n_cmp++; if (result !== 10'h222) begin n_err++; $display("FAIL ovr_second_result: got %h want 222", result); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_cmp++; if ({result_valid, busy} !== 2'b10) begin n_err++; $display("FAIL ovr_valid_busy: got %b want 10", {result_valid, busy}); end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        n_cmp++; if (result !== 10'h222) begin n_err++; $display("FAIL ovr_hold: got %h want 222", result); end
        continuous = 1'b0;
        accept();
    endtask

    task automatic test_back_to_back();
        int ns;
        continuous = 1'b1; mode = 2'b10; avg_log2 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_one(2'd2, 10'h0AA, 2, ns);
        tick();
        mode = 2'b00;
        run_one(2'd2, 10'h155, 2, ns);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", result_valid); end
        n_cmp++; if (result !== 10'h155) begin n_err++; $display("FAIL b2b_result: got %h want 155", result); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        continuous = 1'b0;
        accept();
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got %b want 0", result_valid); end
    endtask

    task automatic test_timeout();
        int g;
        int k;
        continuous = 1'b1; mode = 2'b01; avg_log2 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        clear_flags = 1'b1;   // held so the timeout set collides with a clear
        g = 0;
        while (samp && g < 50) begin tick(); g++; end
        k = 0;
        while (!timeout && k < 200) begin tick(); k++; end
        n_cmp++; if (k !== 64) begin n_err++; $display("FAIL timeout_cycles: got %0d want 64", k); end
        clear_flags = 1'b0;
        n_cmp++; if ({busy, result_valid} !== 2'b00) begin n_err++; $display("FAIL timeout_idle: got %b want 00", {busy, result_valid}); end
        tick();
        n_cmp++; if ({timeout, samp, busy} !== 3'b100) begin n_err++; $display("FAIL timeout_sticky: got %b want 100", {timeout, samp, busy}); end
        continuous = 1'b0;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    endtask

    task automatic test_reset_mid();
        int g;
        int ns;
        mode = 2'b10; avg_log2 = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        g = 0;
        while (samp && g < 50) begin tick(); g++; end
        repeat (3) tick();
        eoc_conv = 1'b1; b_conv = 10'h3C3; wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0; eoc_conv = 1'b0;
        n_cmp++; if ({samp, sel, busy, result, result_valid, overrun, timeout} !== 17'd0) begin n_err++; $display("FAIL rstmid_outputs: got %h want 0", {samp, sel, busy, result, result_valid, overrun, timeout}); end
        tick();
        n_cmp++; if ({busy, result_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid_no_publish: got %b want 00", {busy, result_valid}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        run_one(2'd2, 10'h155, 2, ns);
        tick();
        n_cmp++; if ({result_valid, result} !== {1'b1, 10'h155}) begin n_err++; $display("FAIL rstmid_restart: got %h want 555", {result_valid, result}); end
        accept();
    endtask

    task automatic test_ignore();
        int g;
        int ns;
        mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if ({busy, samp} !== 2'b00) begin n_err++; $display("FAIL ign_mode0: got %b want 00", {busy, samp}); end
        mode = 2'b10; avg_log2 = 2'd1; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b11; avg_log2 = 2'd0;
        g = 0;
        while (samp && g < 50) begin tick(); g++; end
        b_flash = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            eoc_flash = ~eoc_flash;
            start = (i == 1);
            tick();
        end
        eoc_flash = 1'b0; start = 1'b0;
        n_cmp++; if ({sel, busy, samp} !== 4'b1010) begin n_err++; $display("FAIL ign_busy: got %b want 1010", {sel, busy, samp}); end
        eoc_conv = 1'b1; b_conv = 10'h010;
        tick();
        eoc_conv = 1'b0;
        run_one(2'd2, 10'h013, 2, ns);
        tick();
        n_cmp++; if (result !== 10'h011) begin n_err++; $display("FAIL ign_result: got %h want 011", result); end
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL ign_valid: got %b want 1", result_valid); end
        accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_single();
        test_average4();
        test_average8_max();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
Conversion controller that sequences the ADC digital back-ends (Flash, SAR conventional, SAR monotonic). It drives the shared sample strobe and times the sample and convert phases. It watches the selected back-end's end-of-conversion, optionally averages 2^N conversions, and delivers the result through a valid/ready handshake. It sits between the user-area control register or IO and the ADC logic instances, replacing the free-running sample toggle.

Parameters:
NBITS, 10, result width of every back-end
SAMP_CYCLES, 2, cycles the sample strobe is held high per conversion (1..15)
TIMEOUT_CYCLES, 64, max cycles in CONVERT waiting for eoc before abort (2..255)

Ports:
wb_clk_i  in  1  single clock; all logic on posedge
wb_rst_i  in  1  reset, synchronous, active-high
start  in  1  one-cycle request; honoured only in IDLE
continuous  in  1  1 = restart automatically after each published result
mode  in  2  00 off, 01 Flash, 10 SAR conv, 11 SAR monot; latched at start
avg_log2  in  2  average 2^avg_log2 conversions (1,2,4,8); latched at start
clear_flags  in  1  clears overrun and timeout sticky flags
eoc_flash, eoc_conv, eoc_monot  in  1 each  end-of-conversion from the back-ends, level
b_flash, b_conv, b_monot  in  NBITS each  back-end result buses
samp  out  1  sample strobe to all back-ends
sel  out  2  latched mode, drives the output mux
busy  out  1  high whenever state != IDLE
result  out  NBITS  averaged result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result when valid&ready
overrun  out  1  sticky: unread result overwritten
timeout  out  1  sticky: eoc missing for TIMEOUT_CYCLES

Behaviour:
- Reset (sync, on posedge when wb_rst_i=1): state IDLE; samp=0; sel=00; busy=0; result=0; result_valid=0; overrun=0; timeout=0; accumulator, conversion counter and phase counter =0. Reset mid-operation aborts immediately with no result published.
- States: IDLE, SAMPLE, CONVERT, PUBLISH.
- IDLE: start=1 and mode!=00 -> latch mode into sel and avg_log2, clear accumulator and counter -> SAMPLE next cycle. start with mode=00 is ignored.
- SAMPLE: samp=1 for exactly SAMP_CYCLES cycles -> CONVERT. samp is registered; it is high on exactly the cycles spent in SAMPLE.
- CONVERT: samp=0; timeout counter increments each cycle.
  - If eoc of the latched mode is 1: accumulator += selected b_*, counter++, timeout counter cleared.
    - Counter reached 2^avg_log2 -> PUBLISH.
    - Otherwise -> SAMPLE.
  - eoc of the non-selected back-ends is ignored. eoc must be seen at least 1 cycle after entering CONVERT.
  - Timeout counter reaches TIMEOUT_CYCLES without eoc -> timeout=1, accumulator cleared, -> IDLE. No result is published, even in continuous mode.
- Accumulator is NBITS+3 bits and never overflows. Published value = accumulator >> avg_log2 (truncating).
- PUBLISH (one cycle): result <= averaged value; result_valid <= 1 on the next edge.
  - continuous=1 -> SAMPLE with accumulator and counter cleared; mode and avg_log2 are re-latched from the inputs. If the new mode=00 -> IDLE.
  - continuous=0 -> IDLE.
- Handshake: result_valid stays high until a cycle with result_ready=1, then clears on the next edge. result is stable while valid.
- Simultaneous accept and publish in the same cycle: the new result loads, valid stays 1, no overrun.
- Publish while valid=1 and ready=0: result is overwritten, valid stays 1, overrun=1.
- Sticky flags: clear_flags=1 clears overrun and timeout next cycle. If a set event coincides with clear_flags, the set wins.
- Input changes mid-conversion: mode and avg_log2 changes are ignored until the next latch point. start while busy is ignored.

Test Plan:
- Reset, then mode=10, avg_log2=0, start pulse; eoc_conv asserted 5 cycles into CONVERT with b_conv=0x2A5 -> samp high exactly 2 cycles, result=0x2A5, result_valid 1 cycle after PUBLISH, busy low afterwards.
- avg_log2=2, mode=11, b_monot=100,101,102,104 on four eocs -> result=101 (407>>2); exactly 4 samp pulses.
- continuous=1, result_ready held 0 for two publishes -> overrun=1, result holds the second value; clear_flags -> overrun=0.
- mode=01, eoc_flash never asserted -> timeout=1 exactly TIMEOUT_CYCLES cycles after CONVERT entry, state IDLE, result_valid stays 0.
- wb_rst_i asserted during CONVERT with eoc pending -> all outputs 0 on the next edge; a later start works normally.
- start with mode=00, and start pulses while busy -> no state change; eoc_flash toggling during a mode=10 conversion -> ignored.
